uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Byte-level frame decoder sitting directly downstream of the UART receiver on the board-test path. It consumes the receiver's one-cycle `valid`/`data` byte strobes and checks the framing: sync byte, length, payload and XOR checksum. It buffers the payload internally and releases it only after the checksum passes, over a valid/ready stream towards the SPI master stage. Corrupt, malformed or stalled frames are discarded and reported with an error code.

## Interface
- `DATA_BITS`, 8: byte width. Must match the UART receiver.
- `MAX_LEN`, 16: maximum payload bytes per frame; also the internal buffer depth.
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT`, 4096: maximum allowed gap between bytes inside a frame, in `clk` cycles.
- `clk` in 1: single clock, same domain as the UART receiver.
- `n_rst` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle byte strobe from the UART receiver.
- `rx_data` in DATA_BITS: received byte. Sampled only when `rx_valid`=1.
- `tx_data` out DATA_BITS: payload byte to the downstream stage.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts `tx_data` this cycle.
- `frame_done` out 1: one-cycle pulse after the last payload byte is accepted.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `err_code` out 2: cause of the most recent error. 01 = bad length, 10 = checksum, 11 = timeout. Holds its value until the next error or reset.
- `rx_drop` out 1: one-cycle pulse when a byte arrives in SEND and is discarded.
- `busy` out 1: high whenever the state is not HUNT.

## Operation
- **Frame format:** SYNC, LEN, LEN payload bytes, CHK.
  - CHK = LEN XOR every payload byte.
  - Valid LEN range is 1..MAX_LEN.
- **State machine:** HUNT, LEN, PAYLOAD, CHECK, SEND.
- **HUNT:**
  - `rx_valid` with `rx_data`==SYNC: go to LEN.
  - Any other byte: ignored silently; no error, no drop pulse.
- **LEN:**
  - On a byte with value 0 or greater than MAX_LEN: pulse `frame_err`, set `err_code`=01, go to HUNT.
  - Otherwise: latch LEN, initialise the checksum accumulator to LEN, clear the write index, go to PAYLOAD.
- **PAYLOAD:**
  - Each byte is written to `buf[wr_idx]`, XORed into the accumulator, and `wr_idx` increments.
  - After the byte that makes `wr_idx`==LEN, go to CHECK.
- **CHECK:**
  - Next byte equal to the accumulator: go to SEND with `rd_idx`=0.
  - Otherwise: pulse `frame_err`, set `err_code`=10, go to HUNT.
  - No payload is ever presented for a failed frame.
- **SEND:**
  - `tx_data`=`buf[rd_idx]` and `tx_valid`=1.
  - A transfer occurs on a cycle with `tx_valid`&&`tx_ready`; `rd_idx` then increments.
  - On the transfer of byte LEN-1: `tx_valid` falls next cycle, `frame_done` pulses next cycle, state returns to HUNT next cycle.
- **Drops:** any `rx_valid` while in SEND pulses `rx_drop` next cycle and the byte is discarded. This includes a byte arriving on the cycle of the final transfer.
- **Timeout:**
  - The counter is cleared on every `rx_valid` and held at 0 in HUNT and SEND.
  - It increments in LEN, PAYLOAD and CHECK.
  - On reaching TIMEOUT-1 with no byte arriving: pulse `frame_err`, set `err_code`=11, go to HUNT.
  - If a byte arrives on that same cycle, the byte wins and the counter clears.
- **Widths:**
  - `wr_idx`, `rd_idx` and latched LEN are `$clog2(MAX_LEN+1)` bits.
  - The timeout counter is `$clog2(TIMEOUT)` bits.
  - The checksum is DATA_BITS wide.
  - No wrap-around occurs, because LEN ≤ MAX_LEN is enforced.
- **Reset (asynchronous, any state):**
  - State returns to HUNT.
  - All counters, the accumulator and the buffer contents are cleared.
  - A frame in progress or mid-SEND is abandoned, with no `frame_done` or `frame_err`.

## Timing
- **Reset values:** `tx_data`=0, `tx_valid`=0, `frame_done`=0, `frame_err`=0, `err_code`=00, `rx_drop`=0, `busy`=0.
- **Registered outputs:** all outputs are registered. State transitions and pulses appear the cycle after the triggering `rx_valid`.
- **CHK to first byte:** `tx_valid` rises 1 cycle after the CHK strobe. `tx_data` is valid in that same cycle.
- **Throughput:** with `tx_ready` held at 1, LEN bytes stream on LEN consecutive cycles. `frame_done` pulses the cycle after the last transfer.
- **Backpressure:** while `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable. `tx_valid` never drops before its transfer.
- **Back-to-back frames:** a SYNC byte arriving the cycle after `frame_done` is accepted. The next frame's SYNC must therefore arrive after SEND completes, or it is dropped.
- **Pulse widths:** `frame_err`, `frame_done` and `rx_drop` are exactly one cycle wide.

## Test plan
- **Good frame:** bytes A5 03 11 22 33 03 with `tx_ready`=1 → `tx_data` 11, 22, 33 on 3 consecutive cycles with `tx_valid`=1; `frame_done` pulses once; `frame_err`=0.
- **Bad checksum:** A5 02 10 20 31 → `frame_err` pulse, `err_code`=10, `tx_valid` never asserts. A following good frame then decodes correctly.
- **Bad length:** A5 00, then A5 11 (17 > MAX_LEN) → two `frame_err` pulses, `err_code`=01 each time, back to HUNT. A leading 00 FF before SYNC produces no error.
- **Timeout:** A5 02 11 then silence → `frame_err` pulse exactly TIMEOUT cycles after the 11 strobe, `err_code`=11, `busy`=0. A gap of TIMEOUT-2 cycles does not error.
- **Backpressure and drop:** good 4-byte frame with `tx_ready` toggling 1,0,0,1,... → data stable while stalled, all 4 bytes delivered in order. One `rx_valid` injected during SEND → `rx_drop` pulse, payload unaffected.
- **Reset mid-operation:** assert `n_rst`=0 during SEND (after 1 of 3 bytes transferred) → all outputs return to reset values immediately, no `frame_done`. The next good frame decodes normally.

Source files
------------

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / payload-out bundle for the frame decoder; slave is the decoder's view.
interface uart_frame_decoder_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 frame_done;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic                 rx_drop;
  logic                 busy;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_data, tx_valid, frame_done, frame_err, err_code, rx_drop, busy
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_data, tx_valid, frame_done, frame_err, err_code, rx_drop, busy
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Checks SYNC/LEN/payload/XOR-CHK framing and buffers the payload until the checksum passes.
// First tx byte one cycle after CHK; tx_data holds while tx_ready=0, and bytes arriving during SEND are dropped.
module uart_frame_decoder #(
  parameter int                   DATA_BITS = 8,
  parameter int                   MAX_LEN   = 16,
  parameter logic [DATA_BITS-1:0] SYNC      = 8'hA5,
  parameter int                   TIMEOUT   = 4096
) (
  input logic                  clk,
  input logic                  n_rst,
  uart_frame_decoder_if.slave  bus
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [DATA_BITS-1:0] LEN_MAX_B = DATA_BITS'(MAX_LEN);
  localparam logic [CW-1:0]        TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_SEND} state_t;
  state_t state, state_d;

  logic [DATA_BITS-1:0] mem [MAX_LEN];
  logic [IW-1:0]        len_q, wr_idx, rd_idx;
  logic [DATA_BITS-1:0] acc;
  logic [CW-1:0]        to_cnt;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 tx_valid_q, frame_done_q, frame_err_q, rx_drop_q, busy_q;
  logic [1:0]           err_code_q;

  logic       timeout, xfer, last, len_ok;
  logic       tx_valid_d, frame_done_d, frame_err_d, rx_drop_d;
  logic [1:0] err_code_d;

  assign timeout = !bus.rx_valid && (to_cnt == TO_LAST) &&
                   (state inside {S_LEN, S_PAYLOAD, S_CHECK});
  assign xfer    = (state == S_SEND) && tx_valid_q && bus.tx_ready;
  assign last    = (rd_idx == (len_q - IW'(1)));
  assign len_ok  = (bus.rx_data != '0) && (bus.rx_data <= LEN_MAX_B);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_HUNT;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_drop_d    = 1'b0;
    err_code_d   = err_code_q;
    case (state)
      S_HUNT: begin
        if (bus.rx_valid && (bus.rx_data == SYNC)) state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          if (len_ok) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid && ((wr_idx + IW'(1)) == len_q)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == acc) begin
            state_d    = S_SEND;
            tx_valid_d = 1'b1;
          end else begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
          end
        end
      end
      S_SEND: begin
        rx_drop_d = bus.rx_valid;
        if (xfer && last) begin
          state_d      = S_HUNT;
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase
    if (timeout) begin
      state_d     = S_HUNT;
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
      len_q        <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      acc          <= '0;
      to_cnt       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
      err_code_q   <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      rx_drop_q    <= rx_drop_d;
      err_code_q   <= err_code_d;
      busy_q       <= (state_d != S_HUNT);

      // Any byte restarts the inter-byte gap; the counter only runs mid-frame.
      if (bus.rx_valid || timeout || state == S_HUNT || state == S_SEND) to_cnt <= '0;
      else                                                              to_cnt <= to_cnt + CW'(1);

      if (bus.rx_valid) begin
        case (state)
          S_LEN: if (len_ok) begin
            len_q  <= IW'(bus.rx_data);
            acc    <= bus.rx_data;
            wr_idx <= '0;
          end
          S_PAYLOAD: begin
            mem[wr_idx[AW-1:0]] <= bus.rx_data;
            acc                 <= acc ^ bus.rx_data;
            wr_idx              <= wr_idx + IW'(1);
          end
          S_CHECK: if (bus.rx_data == acc) begin
            rd_idx    <= '0;
            tx_data_q <= mem[0];
          end
          default: ;
        endcase
      end

      if (xfer && !last) begin
        rd_idx    <= rd_idx + IW'(1);
        tx_data_q <= mem[rd_idx[AW-1:0] + AW'(1)];
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.rx_drop    = rx_drop_q;
  assign bus.busy       = busy_q;
endmodule
